// File: rtl/xrv_id_q.sv
// RV32I decode stage with a DEPTH-entry decoded-instruction queue between fetch and EX.
// Decode is combinational on the fetch side; the EX side always sees the registered queue head.
module xrv_id_q #(
    parameter int DEPTH        = 2,
    parameter bit JAL_REDIRECT = 1'b1,
    parameter bit ILLEGAL_CHK  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     flush_i,
    input  logic                     inst_valid_i,
    output logic                     inst_ready_o,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              inst_pc_i,
    input  logic                     inst_is_compressed_i,
    output logic                     id_jmp_o,
    output logic [31:0]              id_jmp_addr_o,
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic [10:0]              ex_op_o,
    output logic                     ex_illegal_o,
    output logic [31:0]              ex_imm_signed_o,
    output logic [31:0]              ex_imm_unsigned_o,
    output logic [4:0]               ex_src1_o,
    output logic [4:0]               ex_src2_o,
    output logic [4:0]               ex_dest_o,
    output logic [2:0]               ex_funct3_o,
    output logic                     ex_funct7_bit5_o,
    output logic                     ex_is_compressed_o,
    output logic [31:0]              ex_pc_o,
    output logic [31:0]              ex_pc_link_o,
    output logic [31:0]              ex_pc_target_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [10:0] op;
        logic        illegal;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        is_c;
        logic [31:0] pc;
        logic [31:0] pc_link;
        logic [31:0] pc_target;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          entry_s;
    entry_t          head_s;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [10:0]     op_s;
    logic [31:0]     imm_s_s, imm_u_s;
    logic [31:0]     i_imm_s, s_imm_s, b_imm_s, u_imm_s, j_imm_s;
    logic            full_s, push_s, pop_s;

    assign i_imm_s = {{20{inst_i[31]}}, inst_i[31:20]};
    assign s_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign b_imm_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign u_imm_s = {inst_i[31:12], 12'h000};
    assign j_imm_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Opcode class and immediate selection; the unsigned form keeps only the encoded bits.
    always_comb begin
        op_s    = 11'h000;
        imm_s_s = 32'h0000_0000;
        imm_u_s = 32'h0000_0000;
        case (inst_i[6:0])
            7'b0110111: begin op_s = 11'h001; imm_s_s = u_imm_s; imm_u_s = u_imm_s; end
            7'b0010111: begin op_s = 11'h002; imm_s_s = u_imm_s; imm_u_s = u_imm_s; end
            7'b1101111: begin op_s = 11'h004; imm_s_s = j_imm_s; imm_u_s = {11'h000, j_imm_s[20:0]}; end
            7'b1100111: begin op_s = 11'h008; imm_s_s = i_imm_s; imm_u_s = {20'h00000, i_imm_s[11:0]}; end
            7'b1100011: begin op_s = 11'h010; imm_s_s = b_imm_s; imm_u_s = {19'h00000, b_imm_s[12:0]}; end
            7'b0000011: begin op_s = 11'h020; imm_s_s = i_imm_s; imm_u_s = {20'h00000, i_imm_s[11:0]}; end
            7'b0100011: begin op_s = 11'h040; imm_s_s = s_imm_s; imm_u_s = {20'h00000, s_imm_s[11:0]}; end
            7'b0010011: begin op_s = 11'h080; imm_s_s = i_imm_s; imm_u_s = {20'h00000, i_imm_s[11:0]}; end
            7'b0110011: begin op_s = 11'h100; imm_s_s = 32'h0000_0000; imm_u_s = 32'h0000_0000; end
            7'b0001111: begin op_s = 11'h200; imm_s_s = i_imm_s; imm_u_s = {20'h00000, i_imm_s[11:0]}; end
            7'b1110011: begin op_s = 11'h400; imm_s_s = i_imm_s; imm_u_s = {20'h00000, i_imm_s[11:0]}; end
            default:    begin op_s = 11'h000; imm_s_s = 32'h0000_0000; imm_u_s = 32'h0000_0000; end
        endcase
    end

    assign entry_s.op        = op_s;
    assign entry_s.illegal   = ILLEGAL_CHK && (op_s == 11'h000);
    assign entry_s.imm_s     = imm_s_s;
    assign entry_s.imm_u     = imm_u_s;
    assign entry_s.src1      = inst_i[19:15];
    assign entry_s.src2      = inst_i[24:20];
    assign entry_s.dest      = inst_i[11:7];
    assign entry_s.funct3    = inst_i[14:12];
    assign entry_s.f7b5      = inst_i[30];
    assign entry_s.is_c      = inst_is_compressed_i;
    assign entry_s.pc        = inst_pc_i;
    assign entry_s.pc_link   = inst_pc_i + (inst_is_compressed_i ? 32'd2 : 32'd4);
    assign entry_s.pc_target = inst_pc_i + imm_s_s;

    // Ready depends only on occupancy, so a pop while full cannot admit a push that cycle.
    assign full_s        = (cnt_q == DEPTH_C);
    assign inst_ready_o  = ~full_s;
    assign ex_valid_o    = (cnt_q != {CW{1'b0}});
    assign push_s        = inst_valid_i & ~full_s & ~flush_i;
    assign pop_s         = ex_valid_o & ex_ready_i & ~flush_i;
    assign id_jmp_o      = JAL_REDIRECT && push_s && op_s[2];
    assign id_jmp_addr_o = inst_pc_i + j_imm_s;

    // Pointer and occupancy next state; flush overrides any push or pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = {PW{1'b0}};
            rd_d  = {PW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            wr_d = push_s ? wr_q + PW'(1'b1) : wr_q;
            rd_d = pop_s  ? rd_q + PW'(1'b1) : rd_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1'b1);
                2'b01:   cnt_d = cnt_q - CW'(1'b1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage: cleared by reset only, so a flush leaves stale data behind.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= entry_s;
        end
    end

    assign head_s             = mem_q[rd_q];
    assign ex_op_o            = head_s.op;
    assign ex_illegal_o       = head_s.illegal;
    assign ex_imm_signed_o    = head_s.imm_s;
    assign ex_imm_unsigned_o  = head_s.imm_u;
    assign ex_src1_o          = head_s.src1;
    assign ex_src2_o          = head_s.src2;
    assign ex_dest_o          = head_s.dest;
    assign ex_funct3_o        = head_s.funct3;
    assign ex_funct7_bit5_o   = head_s.f7b5;
    assign ex_is_compressed_o = head_s.is_c;
    assign ex_pc_o            = head_s.pc;
    assign ex_pc_link_o       = head_s.pc_link;
    assign ex_pc_target_o     = head_s.pc_target;
    assign q_count_o          = cnt_q;
endmodule

// File: tb/tb_xrv_id_q.sv
// Bench for xrv_id_q: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_xrv_id_q;
    localparam int DEPTH = 2;

    logic        clk = 1'b0, rstb = 1'b0, flush = 1'b0, inst_valid = 1'b0, ex_ready = 1'b0, inst_c = 1'b0;
    logic [31:0] inst = 32'h0, inst_pc = 32'h0;

    logic        inst_ready, id_jmp, ex_valid, ex_illegal, ex_f7, ex_c;
    logic [31:0] id_jmp_addr, ex_imm_s, ex_imm_u, ex_pc, ex_link, ex_tgt;
    logic [10:0] ex_op;
    logic [4:0]  ex_src1, ex_src2, ex_dest;
    logic [2:0]  ex_funct3;
    logic [1:0]  q_count;

    logic        inst_ready0, id_jmp0, ex_valid0, ex_illegal0, ex_f70, ex_c0;
    logic [31:0] id_jmp_addr0, ex_imm_s0, ex_imm_u0, ex_pc0, ex_link0, ex_tgt0;
    logic [10:0] ex_op0;
    logic [4:0]  ex_src10, ex_src20, ex_dest0;
    logic [2:0]  ex_funct30;
    logic [1:0]  q_count0;

    int checks = 0, failures = 0;

    typedef struct {
        logic [10:0] op;
        logic        ill;
        logic [31:0] imm_s, imm_u;
        logic [4:0]  s1, s2, rd;
        logic [2:0]  f3;
        logic        f7, c;
        logic [31:0] pc, link, tgt;
    } exp_t;
    exp_t mq[$];

    wire [191:0] pay  = {ex_op, ex_illegal, ex_imm_s, ex_imm_u, ex_src1, ex_src2, ex_dest,
                         ex_funct3, ex_f7, ex_c, ex_pc, ex_link, ex_tgt};
    wire [191:0] pay0 = {ex_op0, ex_illegal0, ex_imm_s0, ex_imm_u0, ex_src10, ex_src20, ex_dest0,
                         ex_funct30, ex_f70, ex_c0, ex_pc0, ex_link0, ex_tgt0};

    xrv_id_q #(.DEPTH(DEPTH), .JAL_REDIRECT(1'b1), .ILLEGAL_CHK(1'b1)) u_dut (
        .clk(clk), .rstb(rstb), .flush_i(flush), .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
        .inst_i(inst), .inst_pc_i(inst_pc), .inst_is_compressed_i(inst_c),
        .id_jmp_o(id_jmp), .id_jmp_addr_o(id_jmp_addr), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_op_o(ex_op), .ex_illegal_o(ex_illegal), .ex_imm_signed_o(ex_imm_s), .ex_imm_unsigned_o(ex_imm_u),
        .ex_src1_o(ex_src1), .ex_src2_o(ex_src2), .ex_dest_o(ex_dest), .ex_funct3_o(ex_funct3),
        .ex_funct7_bit5_o(ex_f7), .ex_is_compressed_o(ex_c), .ex_pc_o(ex_pc), .ex_pc_link_o(ex_link),
        .ex_pc_target_o(ex_tgt), .q_count_o(q_count));

    xrv_id_q #(.DEPTH(DEPTH), .JAL_REDIRECT(1'b0), .ILLEGAL_CHK(1'b0)) u_dut0 (
        .clk(clk), .rstb(rstb), .flush_i(flush), .inst_valid_i(inst_valid), .inst_ready_o(inst_ready0),
        .inst_i(inst), .inst_pc_i(inst_pc), .inst_is_compressed_i(inst_c),
        .id_jmp_o(id_jmp0), .id_jmp_addr_o(id_jmp_addr0), .ex_valid_o(ex_valid0), .ex_ready_i(ex_ready),
        .ex_op_o(ex_op0), .ex_illegal_o(ex_illegal0), .ex_imm_signed_o(ex_imm_s0), .ex_imm_unsigned_o(ex_imm_u0),
        .ex_src1_o(ex_src10), .ex_src2_o(ex_src20), .ex_dest_o(ex_dest0), .ex_funct3_o(ex_funct30),
        .ex_funct7_bit5_o(ex_f70), .ex_is_compressed_o(ex_c0), .ex_pc_o(ex_pc0), .ex_pc_link_o(ex_link0),
        .ex_pc_target_o(ex_tgt0), .q_count_o(q_count0));

    always #5 clk = ~clk;

    // Reference decode: pick the class, gather the encoded immediate bits, sign-extend by field width.
    function automatic exp_t model_decode(input logic [31:0] in, input logic [31:0] pc, input logic c);
        exp_t e;
        int cls, n;
        logic [31:0] raw;
        logic signed [31:0] t;
        cls = -1; raw = 32'h0; n = 32;
        case (in[6:0])
            7'h37, 7'h17: begin cls = (in[5] ? 0 : 1); raw = {in[31:12], 12'h000}; end
            7'h6F: begin cls = 2; raw = {11'h0, in[31], in[19:12], in[20], in[30:21], 1'b0}; n = 21; end
            7'h67: begin cls = 3; raw = {20'h0, in[31:20]}; n = 12; end
            7'h63: begin cls = 4; raw = {19'h0, in[31], in[7], in[30:25], in[11:8], 1'b0}; n = 13; end
            7'h03: begin cls = 5; raw = {20'h0, in[31:20]}; n = 12; end
            7'h23: begin cls = 6; raw = {20'h0, in[31:25], in[11:7]}; n = 12; end
            7'h13: begin cls = 7; raw = {20'h0, in[31:20]}; n = 12; end
            7'h33: begin cls = 8; end
            7'h0F: begin cls = 9; raw = {20'h0, in[31:20]}; n = 12; end
            7'h73: begin cls = 10; raw = {20'h0, in[31:20]}; n = 12; end
            default: cls = -1;
        endcase
        t = raw << (32 - n);
        t = t >>> (32 - n);
        e.op    = (cls < 0) ? 11'h000 : 11'(1 << cls);
        e.ill   = (cls < 0);
        e.imm_u = raw;
        e.imm_s = t;
        e.s1 = in[19:15]; e.s2 = in[24:20]; e.rd = in[11:7]; e.f3 = in[14:12]; e.f7 = in[30];
        e.c = c; e.pc = pc;
        e.link = pc + (c ? 32'd2 : 32'd4);
        e.tgt  = pc + e.imm_s;
        return e;
    endfunction

    function automatic logic [191:0] pack(input exp_t h, input logic ill_en);
        return {h.op, h.ill & ill_en, h.imm_s, h.imm_u, h.s1, h.s2, h.rd, h.f3, h.f7, h.c, h.pc, h.link, h.tgt};
    endfunction

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        bit push, pop;
        exp_t e;
        push = inst_valid && (mq.size() < DEPTH) && !flush;
        pop  = ex_ready && (mq.size() > 0) && !flush;
        e = model_decode(inst, inst_pc, inst_c);
        @(posedge clk); #1;
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({ex_valid, q_count, ex_op, ex_illegal} !== 15'h0) begin failures++;
            $display("FAIL reset_in: got valid=%0d cnt=%0d op=%h ill=%0d, want all 0", ex_valid, q_count, ex_op, ex_illegal); end
        checks++; if (pay !== 192'h0) begin failures++; $display("FAIL reset_payload: got %h want 0", pay); end
        @(posedge clk); #1 rstb = 1'b1;
        @(negedge clk);
        checks++; if ({ex_valid, inst_ready, q_count, id_jmp} !== 5'b01000) begin failures++;
            $display("FAIL reset_idle: got valid=%0d ready=%0d cnt=%0d jmp=%0d want 0 1 0 0", ex_valid, inst_ready, q_count, id_jmp); end
    endtask

    task automatic test_addi();
        inst = 32'hFFF00093; inst_pc = 32'h100; inst_valid = 1'b1; ex_ready = 1'b0;
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        checks++; if (ex_valid !== 1'b1 || ex_op !== 11'h080) begin failures++;
            $display("FAIL addi_op: got valid=%0d op=%h want 1 080", ex_valid, ex_op); end
        checks++; if (ex_imm_s !== 32'hFFFFFFFF || ex_imm_u !== 32'h00000FFF) begin failures++;
            $display("FAIL addi_imm: got s=%h u=%h want FFFFFFFF 00000FFF", ex_imm_s, ex_imm_u); end
        checks++; if (ex_pc_link_chk(ex_link) !== 32'h104 || ex_dest !== 5'd1) begin failures++;
            $display("FAIL addi_link: got link=%h rd=%0d want 104 1", ex_link, ex_dest); end
        ex_ready = 1'b1; tick(); ex_ready = 1'b0;
    endtask

    function automatic logic [31:0] ex_pc_link_chk(input logic [31:0] v);
        return v;
    endfunction

    task automatic test_full();
        ex_ready = 1'b0; inst_valid = 1'b1; inst = 32'h00100093;
        inst_pc = 32'h300; tick();
        inst_pc = 32'h304; tick();
        inst_pc = 32'h308;
        @(negedge clk);
        checks++; if (inst_ready !== 1'b0 || q_count !== 2'd2 || ex_pc !== 32'h300) begin failures++;
            $display("FAIL full_stall: got ready=%0d cnt=%0d pc=%h want 0 2 300", inst_ready, q_count, ex_pc); end
        tick();
        @(negedge clk);
        checks++; if (q_count !== 2'd2) begin failures++; $display("FAIL full_hold: got cnt=%0d want 2", q_count); end
        ex_ready = 1'b1; tick();
        @(negedge clk);
        checks++; if (ex_pc !== 32'h304 || q_count !== 2'd1) begin failures++;
            $display("FAIL drain1: got pc=%h cnt=%0d want 304 1", ex_pc, q_count); end
        tick();
        @(negedge clk);
        checks++; if (ex_pc !== 32'h308 || q_count !== 2'd1) begin failures++;
            $display("FAIL drain2: got pc=%h cnt=%0d want 308 1", ex_pc, q_count); end
        inst_valid = 1'b0; tick();
        @(negedge clk);
        checks++; if (ex_valid !== 1'b0 || q_count !== 2'd0) begin failures++;
            $display("FAIL drain_empty: got valid=%0d cnt=%0d want 0 0", ex_valid, q_count); end
        ex_ready = 1'b0;
    endtask

    task automatic test_jal();
        inst = 32'h0080006F; inst_pc = 32'h200; inst_valid = 1'b1; ex_ready = 1'b0;
        @(negedge clk);
        checks++; if (id_jmp !== 1'b1 || id_jmp_addr !== 32'h208) begin failures++;
            $display("FAIL jal_redirect: got jmp=%0d addr=%h want 1 208", id_jmp, id_jmp_addr); end
        checks++; if (id_jmp0 !== 1'b0 || id_jmp_addr0 !== 32'h208) begin failures++;
            $display("FAIL jal_noredirect: got jmp=%0d addr=%h want 0 208", id_jmp0, id_jmp_addr0); end
        tick(); inst_valid = 1'b0;
        @(negedge clk);
        checks++; if (ex_op !== 11'h004 || ex_link !== 32'h204 || ex_tgt !== 32'h208) begin failures++;
            $display("FAIL jal_entry: got op=%h link=%h tgt=%h want 004 204 208", ex_op, ex_link, ex_tgt); end
        ex_ready = 1'b1; tick(); ex_ready = 1'b0;
        inst_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++; if (id_jmp !== 1'b0) begin failures++; $display("FAIL jal_flush_jmp: got %0d want 0", id_jmp); end
        tick(); flush = 1'b0; inst_valid = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 2'd0 || ex_valid !== 1'b0) begin failures++;
            $display("FAIL jal_flush_q: got cnt=%0d valid=%0d want 0 0", q_count, ex_valid); end
    endtask

    task automatic test_flush_full();
        inst = 32'h00000013; inst_valid = 1'b1; ex_ready = 1'b0;
        inst_pc = 32'h500; tick(); inst_pc = 32'h504; tick();
        inst_valid = 1'b0; ex_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++; if (q_count !== 2'd2) begin failures++; $display("FAIL ff_pre: got cnt=%0d want 2", q_count); end
        tick(); flush = 1'b0; ex_ready = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 2'd0 || ex_valid !== 1'b0) begin failures++;
            $display("FAIL ff_post: got cnt=%0d valid=%0d want 0 0", q_count, ex_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [4]  = '{32'h0000007F, 32'h00000010, 32'h00001017, 32'h00000013};
        logic [31:0] pcs [4]  = '{32'h400, 32'h404, 32'hFFFFF000, 32'hFFFFFFFE};
        logic        cs  [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] tg  [4]  = '{32'h400, 32'h404, 32'h00000000, 32'hFFFFFFFE};
        logic [31:0] lk  [4]  = '{32'h404, 32'h408, 32'hFFFFF004, 32'h00000000};
        logic        il  [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            inst = ins[k]; inst_pc = pcs[k]; inst_c = cs[k]; inst_valid = 1'b1; ex_ready = 1'b0;
            tick(); inst_valid = 1'b0; ex_ready = 1'b1;
            @(negedge clk);
            checks++; if (ex_illegal !== il[k] || (il[k] && ex_op !== 11'h000) || ex_illegal0 !== 1'b0) begin failures++;
                $display("FAIL illegal_%0d: got ill=%0d op=%h ill0=%0d want %0d", k, ex_illegal, ex_op, ex_illegal0, il[k]); end
            checks++; if (ex_tgt !== tg[k] || ex_link !== lk[k]) begin failures++;
                $display("FAIL pcwrap_%0d: got tgt=%h link=%h want %h %h", k, ex_tgt, ex_link, tg[k], lk[k]); end
            tick();
        end
        ex_ready = 1'b0; inst_c = 1'b0;
    endtask

    task automatic test_reset_mid();
        inst = 32'h12345037; inst_valid = 1'b1; ex_ready = 1'b0;
        inst_pc = 32'h600; tick(); inst_pc = 32'h604; tick();
        inst_valid = 1'b0;
        #2 rstb = 1'b0; mq.delete();
        #1;
        checks++; if (ex_valid !== 1'b0 || q_count !== 2'd0 || pay !== 192'h0) begin failures++;
            $display("FAIL reset_mid: got valid=%0d cnt=%0d pay=%h want empty and cleared", ex_valid, q_count, pay); end
        @(posedge clk); #1 rstb = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] opc [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(7) != 0) r[6:0] = opc[$urandom_range(10)];
            inst = r; inst_pc = $urandom; inst_c = 1'($urandom_range(1));
            inst_valid = ($urandom_range(9) < 7); ex_ready = ($urandom_range(9) < 6);
            flush = ($urandom_range(15) == 0);
            @(negedge clk);
            checks++; if ({ex_valid, inst_ready, q_count} !== {mq.size() != 0, mq.size() < DEPTH, 2'(mq.size())} ||
                          {ex_valid0, inst_ready0, q_count0} !== {ex_valid, inst_ready, q_count}) begin failures++;
                $display("FAIL rnd_ctl[%0d]: got v=%0d r=%0d c=%0d want size %0d", i, ex_valid, inst_ready, q_count, mq.size()); end
            checks++; if (id_jmp !== (inst_valid && mq.size() < DEPTH && !flush && inst[6:0] == 7'h6F) || id_jmp0 !== 1'b0 ||
                          (id_jmp && id_jmp_addr !== model_decode(inst, inst_pc, inst_c).tgt)) begin failures++;
                $display("FAIL rnd_jmp[%0d]: got jmp=%0d addr=%h jmp0=%0d", i, id_jmp, id_jmp_addr, id_jmp0); end
            if (mq.size() > 0) begin
                checks++; if (pay !== pack(mq[0], 1'b1) || pay0 !== pack(mq[0], 1'b0)) begin failures++;
                    $display("FAIL rnd_head[%0d]: got %h want %h", i, pay, pack(mq[0], 1'b1)); end
            end
            tick();
        end
        flush = 1'b0; inst_valid = 1'b0; ex_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_full();
        test_jal();
        test_flush_full();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
